// File: rtl/hs_burst_source.sv
// Valid/ready burst transmitter: one command (base, len) yields len incrementing words with last/done.
// Optional stall counter output enabled by defining HS_BURST_SOURCE_STALL_CNT_EN.
module hs_burst_source #(
  parameter int WORD_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WORD_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data,
  output logic                  output_last,
  output logic                  busy,
  output logic                  done
`ifdef HS_BURST_SOURCE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [LEN_WIDTH-1:0]  REM_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  REM_TWO  = LEN_WIDTH'(2);
  localparam logic [WORD_WIDTH-1:0] WORD_ONE = WORD_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    cmd_fire;
  logic                    out_fire;

  // cmd_ready depends only on registered state, so no path from cmd_valid.
  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign out_fire  = (state_q == SEND) && output_ready;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SEND;
            data_d  = cmd_base;
            rem_d   = cmd_len;
            last_d  = (cmd_len == REM_ONE);
          end
        end
      end
      SEND: begin
        if (out_fire) begin
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            rem_d   = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Data wraps naturally at the word width.
            data_d = data_q + WORD_ONE;
            rem_d  = rem_q - REM_ONE;
            last_d = (rem_q == REM_TWO);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign output_valid = (state_q == SEND);
  assign busy         = (state_q == SEND);
  assign output_data  = data_q;
  assign output_last  = last_q;
  assign done         = done_q;

`ifdef HS_BURST_SOURCE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Cleared on accept, saturating, and held in IDLE for readback after a burst.
  always_comb begin
    stall_d = stall_q;
    if (cmd_fire) begin
      stall_d = '0;
    end else if (output_valid && !output_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_hs_burst_source.sv
// Directed bench for hs_burst_source: bursts, wrap, zero length, stalls, back-to-back, async abort.
module tb_hs_burst_source;

  logic        clock;
  logic        clear_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_base;
  logic [7:0]  cmd_len;
  logic        output_valid;
  logic        output_ready;
  logic [9:0]  output_data;
  logic        output_last;
  logic        busy;
  logic        done;
`ifdef HS_BURST_SOURCE_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  hs_burst_source #(.WORD_WIDTH(10), .LEN_WIDTH(8)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .output_last  (output_last),
    .busy         (busy),
`ifdef HS_BURST_SOURCE_STALL_CNT_EN
    .stall_count  (stall_count),
`endif
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Checks one presented word, then advances a cycle (caller sets output_ready).
  task automatic expect_word(input string tag, input logic [9:0] d, input logic l);
    chk({tag, "_valid"}, {31'd0, output_valid}, 32'd1);
    chk({tag, "_busy"},  {31'd0, busy},         32'd1);
    chk({tag, "_data"},  {22'd0, output_data},  {22'd0, d});
    chk({tag, "_last"},  {31'd0, output_last},  {31'd0, l});
    chk({tag, "_done"},  {31'd0, done},         32'd0);
    step();
  endtask

  task automatic issue(input logic [9:0] b, input logic [7:0] n);
    cmd_valid = 1'b1;
    cmd_base  = b;
    cmd_len   = n;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done1"},  {31'd0, done},         32'd1);
    chk({tag, "_valid0"}, {31'd0, output_valid}, 32'd0);
    chk({tag, "_busy0"},  {31'd0, busy},         32'd0);
    chk({tag, "_last0"},  {31'd0, output_last},  32'd0);
    step();
    chk({tag, "_done0"},  {31'd0, done},         32'd0);
  endtask

  logic [31:0] pat;
  logic [9:0]  exp_w [0:6];
  logic        exp_l [0:6];
  int          nrx, ndone, gap, ncmd, cyc;
  logic        after_first, second_seen;

  initial begin
    clear_n      = 1'b0;
    cmd_valid    = 1'b1;
    cmd_base     = 10'h155;
    cmd_len      = 8'd3;
    output_ready = 1'b1;

    // Reset state; commands offered during reset must be ignored.
    #3;
    chk("rst_valid", {31'd0, output_valid}, 32'd0);
    chk("rst_data",  {22'd0, output_data},  32'd0);
    chk("rst_last",  {31'd0, output_last},  32'd0);
    chk("rst_busy",  {31'd0, busy},         32'd0);
    chk("rst_done",  {31'd0, done},         32'd0);
    step();
    step();
    chk("rst_hold_valid", {31'd0, output_valid}, 32'd0);
    cmd_valid = 1'b0;
    clear_n   = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, output_valid}, 32'd0);

    // 1: four-word burst at full throughput
    issue(10'h010, 8'd4);
    expect_word("t1w0", 10'h010, 1'b0);
    expect_word("t1w1", 10'h011, 1'b0);
    expect_word("t1w2", 10'h012, 1'b0);
    expect_word("t1w3", 10'h013, 1'b1);
    expect_done("t1");

    // 2: data wraps at the word width
    issue(10'h3FE, 8'd3);
    expect_word("t2w0", 10'h3FE, 1'b0);
    expect_word("t2w1", 10'h3FF, 1'b0);
    expect_word("t2w2", 10'h000, 1'b1);
    expect_done("t2");

    // 3: zero-length command gives only a done pulse
    issue(10'h0AA, 8'd0);
    chk("t3_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    expect_done("t3");
    chk("t3_cmd_ready2", {31'd0, cmd_ready}, 32'd1);

    // 4: stalls freeze the presented word (ready pattern 1,0,0,1,1)
    output_ready = 1'b0;
    step();
    output_ready = 1'b1;
    issue(10'h100, 8'd3);
    output_ready = 1'b1;
    expect_word("t4w0", 10'h100, 1'b0);
    output_ready = 1'b0;
    expect_word("t4s0", 10'h101, 1'b0);
    expect_word("t4s1", 10'h101, 1'b0);
    output_ready = 1'b1;
    expect_word("t4w1", 10'h101, 1'b0);
    expect_word("t4w2", 10'h102, 1'b1);
    expect_done("t4");
`ifdef HS_BURST_SOURCE_STALL_CNT_EN
    chk("t4_stall_count", {16'd0, stall_count}, 32'd2);
`endif

    // 5: back-to-back commands (5 then 2) into a randomly stalling receiver
    pat = 32'b1011_0011_1101_0110_1110_0101_1011_0111;
    for (int i = 0; i < 5; i++) begin
      exp_w[i] = 10'h020 + 10'(i);
      exp_l[i] = (i == 4);
    end
    exp_w[5] = 10'h050; exp_l[5] = 1'b0;
    exp_w[6] = 10'h051; exp_l[6] = 1'b1;
    nrx = 0; ndone = 0; gap = 0; ncmd = 0;
    after_first = 1'b0; second_seen = 1'b0;
    cmd_valid = 1'b1; cmd_base = 10'h020; cmd_len = 8'd5;
    for (cyc = 0; cyc < 80 && ndone < 2; cyc++) begin
      output_ready = pat[cyc % 32];
      if (done) ndone++;
      if (after_first && !second_seen) begin
        if (output_valid) second_seen = 1'b1;
        else gap++;
      end
      if (output_valid && output_ready) begin
        if (nrx < 7) begin
          chk("t5_data", {22'd0, output_data}, {22'd0, exp_w[nrx]});
          chk("t5_last", {31'd0, output_last}, {31'd0, exp_l[nrx]});
        end
        if (nrx == 4) after_first = 1'b1;
        nrx++;
      end
      if (cmd_valid && cmd_ready) begin
        ncmd++;
        step();
        if (ncmd == 1) begin
          cmd_base = 10'h050;
          cmd_len  = 8'd2;
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;
    chk("t5_words", nrx, 32'd7);
    chk("t5_dones", ndone, 32'd2);
    chk("t5_gap", gap, 32'd1);
    output_ready = 1'b1;
    step();

    // 6: asynchronous abort in the middle of an 8-word burst
    issue(10'h200, 8'd8);
    expect_word("t6w0", 10'h200, 1'b0);
    expect_word("t6w1", 10'h201, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    chk("t6_valid_async", {31'd0, output_valid}, 32'd0);
    chk("t6_busy_async",  {31'd0, busy},         32'd0);
    chk("t6_data_async",  {22'd0, output_data},  32'd0);
    chk("t6_last_async",  {31'd0, output_last},  32'd0);
    step();
    chk("t6_no_done_rst", {31'd0, done}, 32'd0);
    clear_n = 1'b1;
    step();
    chk("t6_no_done_rel", {31'd0, done}, 32'd0);
    chk("t6_idle_valid",  {31'd0, output_valid}, 32'd0);
    issue(10'h0AB, 8'd2);
    expect_word("t6n0", 10'h0AB, 1'b0);
    expect_word("t6n1", 10'h0AC, 1'b1);
    expect_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
